// File: rtl/cgra_tile.sv
// cgra_tile: one CGRA processing element.
// 8x32 register file, single-cycle ALU, one 64-bit instruction per clock.
// Exchanges words with data memory and neighbouring tiles over 8 lanes.
// Build option: define TILE_MUL_EN to enable op A (MUL); otherwise op A is a NOP.
module cgra_tile #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned NREG    = 8,
    parameter int unsigned NLANE   = 8,
    parameter int unsigned MADDR_W = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [63:0]             instruction,
    input  logic [DATA_W-1:0]       recv_from_memory_data,
    input  logic [2:0]              recv_from_memory_addr,
    output logic [DATA_W-1:0]       send_to_memory_data,
    output logic [MADDR_W-1:0]      send_to_memory_addr,
    input  logic [NLANE*DATA_W-1:0] recv_from_tile_data,
    input  logic [NLANE*3-1:0]      recv_from_tile_addr,
    output logic [NLANE*DATA_W-1:0] send_to_tile_data,
    output logic [NLANE*3-1:0]      send_to_tile_addr,
    output logic [DATA_W-1:0]       final_output
);

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_MOV  = 4'h1,
        OP_ADD  = 4'h2,
        OP_SUB  = 4'h3,
        OP_AND  = 4'h4,
        OP_OR   = 4'h5,
        OP_LDI  = 4'h6,
        OP_XOR  = 4'h7,
        OP_SHL  = 4'h8,
        OP_SHR  = 4'h9,
        OP_MUL  = 4'hA,
        OP_STM  = 4'hB,
        OP_SNDT = 4'hC,
        OP_RCVT = 4'hD,
        OP_OUT  = 4'hE,
        OP_LDM  = 4'hF
    } op_t;

    op_t                op;
    logic [2:0]         rd;
    logic [2:0]         rs1;
    logic [2:0]         rs2;
    logic [2:0]         lane;
    logic [MADDR_W-1:0] maddr;
    logic [DATA_W-1:0]  imm;
    logic               unused_rsvd;

    logic [DATA_W-1:0]  regs [NREG];
    logic [DATA_W-1:0]  a;
    logic [DATA_W-1:0]  b;

    logic               wr_en;
    logic [2:0]         wr_idx;
    logic [DATA_W-1:0]  wr_data;

    assign op          = op_t'(instruction[3:0]);
    assign rd          = instruction[6:4];
    assign rs1         = instruction[9:7];
    assign rs2         = instruction[12:10];
    assign lane        = instruction[15:13];
    assign maddr       = instruction[25:16];
    assign imm         = instruction[63:32];
    assign unused_rsvd = ^instruction[31:26];

    assign a = regs[rs1];
    assign b = regs[rs2];

    // Decode the instruction into at most one register write.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = rd;
        wr_data = '0;
        case (op)
            OP_MOV: begin wr_en = 1'b1; wr_data = a;                 end
            OP_ADD: begin wr_en = 1'b1; wr_data = a + b;             end
            OP_SUB: begin wr_en = 1'b1; wr_data = a - b;             end
            OP_AND: begin wr_en = 1'b1; wr_data = a & b;             end
            OP_OR:  begin wr_en = 1'b1; wr_data = a | b;             end
            OP_LDI: begin wr_en = 1'b1; wr_data = imm;               end
            OP_XOR: begin wr_en = 1'b1; wr_data = a ^ b;             end
            OP_SHL: begin wr_en = 1'b1; wr_data = a << b[4:0];       end
            OP_SHR: begin wr_en = 1'b1; wr_data = a >> b[4:0];       end
`ifdef TILE_MUL_EN
            OP_MUL: begin wr_en = 1'b1; wr_data = a * b;             end
`endif
            OP_RCVT: begin
                wr_en   = 1'b1;
                wr_idx  = recv_from_tile_addr[3*lane +: 3];
                wr_data = recv_from_tile_data[DATA_W*lane +: DATA_W];
            end
            OP_LDM: begin
                wr_en   = 1'b1;
                wr_idx  = recv_from_memory_addr;
                wr_data = recv_from_memory_data;
            end
            default: ;
        endcase
    end

    // Register file: async clear, single write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[wr_idx] <= wr_data;
        end
    end

    // Registered outputs: each holds until its owning op overwrites it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            send_to_memory_data <= '0;
            send_to_memory_addr <= '0;
            send_to_tile_data   <= '0;
            send_to_tile_addr   <= '0;
            final_output        <= '0;
        end else begin
            case (op)
                OP_STM: begin
                    send_to_memory_data <= a;
                    send_to_memory_addr <= maddr;
                end
                OP_SNDT: begin
                    send_to_tile_data[DATA_W*lane +: DATA_W] <= a;
                    send_to_tile_addr[3*lane +: 3]           <= rd;
                end
                OP_OUT:  final_output <= a;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cgra_tile.sv
// tb_cgra_tile: directed + randomized check of cgra_tile against an
// instruction-level reference model of the tile.
module tb_cgra_tile;

    logic         clk;
    logic         rst;
    logic [63:0]  instruction;
    logic [31:0]  recv_from_memory_data;
    logic [2:0]   recv_from_memory_addr;
    logic [31:0]  send_to_memory_data;
    logic [9:0]   send_to_memory_addr;
    logic [255:0] recv_from_tile_data;
    logic [23:0]  recv_from_tile_addr;
    logic [255:0] send_to_tile_data;
    logic [23:0]  send_to_tile_addr;
    logic [31:0]  final_output;

    int n_total;
    int n_bad;

`ifdef TILE_MUL_EN
    localparam logic [31:0] EXP_MUL = 32'd42;
`else
    localparam logic [31:0] EXP_MUL = 32'd0;
`endif

    // Reference model state
    logic [31:0]  m_reg [8];
    logic [31:0]  m_fo;
    logic [31:0]  m_md;
    logic [9:0]   m_ma;
    logic [255:0] m_td;
    logic [23:0]  m_ta;

    cgra_tile dut (
        .clk                   (clk),
        .rst                   (rst),
        .instruction           (instruction),
        .recv_from_memory_data (recv_from_memory_data),
        .recv_from_memory_addr (recv_from_memory_addr),
        .send_to_memory_data   (send_to_memory_data),
        .send_to_memory_addr   (send_to_memory_addr),
        .recv_from_tile_data   (recv_from_tile_data),
        .recv_from_tile_addr   (recv_from_tile_addr),
        .send_to_tile_data     (send_to_tile_data),
        .send_to_tile_addr     (send_to_tile_addr),
        .final_output          (final_output)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ins(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2,
                                        input logic [2:0] lane, input logic [9:0] maddr,
                                        input logic [31:0] imm);
        return {imm, 6'b0, maddr, lane, rs2, rs1, rd, op};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_fo = '0;
        m_md = '0;
        m_ma = '0;
        m_td = '0;
        m_ta = '0;
    endtask

    // Instruction semantics straight from the ISA table.
    task automatic model_exec(input logic [63:0] w);
        logic [3:0]  op;
        logic [2:0]  rd, rs1, rs2, lane, dst;
        logic [31:0] x, y;
        logic [63:0] prod;
        op   = w[3:0];
        rd   = w[6:4];
        rs1  = w[9:7];
        rs2  = w[12:10];
        lane = w[15:13];
        x    = m_reg[rs1];
        y    = m_reg[rs2];
        case (op)
            4'h1: m_reg[rd] = x;
            4'h2: m_reg[rd] = x + y;
            4'h3: m_reg[rd] = x - y;
            4'h4: m_reg[rd] = x & y;
            4'h5: m_reg[rd] = x | y;
            4'h6: m_reg[rd] = w[63:32];
            4'h7: m_reg[rd] = x ^ y;
            4'h8: m_reg[rd] = x << (y % 32);
            4'h9: m_reg[rd] = x >> (y % 32);
            4'hA: begin
`ifdef TILE_MUL_EN
                prod      = {32'd0, x} * {32'd0, y};
                m_reg[rd] = prod[31:0];
`else
                prod      = '0;
`endif
            end
            4'hB: begin m_md = x; m_ma = w[25:16]; end
            4'hC: begin m_td[lane*32 +: 32] = x; m_ta[lane*3 +: 3] = rd; end
            4'hD: begin
                dst        = recv_from_tile_addr[lane*3 +: 3];
                m_reg[dst] = recv_from_tile_data[lane*32 +: 32];
            end
            4'hE: m_fo = x;
            4'hF: m_reg[recv_from_memory_addr] = recv_from_memory_data;
            default: ;
        endcase
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".fo"},  final_output,        m_fo);
        check({tag, ".md"},  send_to_memory_data, m_md);
        check({tag, ".ma"},  send_to_memory_addr, m_ma);
        check({tag, ".td"},  send_to_tile_data,   m_td);
        check({tag, ".ta"},  send_to_tile_addr,   m_ta);
    endtask

    task automatic step(input logic [63:0] w, input string tag);
        instruction = w;
        @(posedge clk);
        model_exec(w);
        #1;
        compare_all(tag);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, ".fo"}, final_output,        '0);
        check({tag, ".md"}, send_to_memory_data, '0);
        check({tag, ".ma"}, send_to_memory_addr, '0);
        check({tag, ".td"}, send_to_tile_data,   '0);
        check({tag, ".ta"}, send_to_tile_addr,   '0);
    endtask

    initial begin
        logic [255:0] other;
        n_total = 0;
        n_bad   = 0;
        rst                   = 1'b1;
        instruction           = '0;
        recv_from_memory_data = '0;
        recv_from_memory_addr = '0;
        recv_from_tile_data   = '0;
        recv_from_tile_addr   = '0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        step(ins(4'hE, 3'd0, 3'd0, 3'd0, 3'd0, 10'd0, 32'd0), "out_r0");
        check("out_r0_const", final_output, 32'd0);

        // ADD
        step(ins(4'h6, 3'd1, 3'd0, 3'd0, 3'd0, 10'd0, 32'h0000000F), "ldi");
        step(ins(4'h2, 3'd2, 3'd1, 3'd1, 3'd0, 10'd0, 32'd0), "add");
        step(ins(4'hE, 3'd0, 3'd2, 3'd0, 3'd0, 10'd0, 32'd0), "out_add");
        check("add_const", final_output, 32'h0000001E);

        // SUB wrap + STM at top address
        step(ins(4'h6, 3'd3, 3'd0, 3'd0, 3'd0, 10'd0, 32'd0), "ldi");
        step(ins(4'h6, 3'd4, 3'd0, 3'd0, 3'd0, 10'd0, 32'd1), "ldi");
        step(ins(4'h3, 3'd5, 3'd3, 3'd4, 3'd0, 10'd0, 32'd0), "sub");
        step(ins(4'hB, 3'd0, 3'd5, 3'd0, 3'd0, 10'h3FF, 32'd0), "stm");
        check("stm_data_const", send_to_memory_data, 32'hFFFFFFFF);
        check("stm_addr_const", send_to_memory_addr, 10'h3FF);

        // SNDT on lane 5 only
        step(ins(4'h6, 3'd1, 3'd0, 3'd0, 3'd0, 10'd0, 32'hA5A5A5A5), "ldi");
        step(ins(4'hC, 3'd6, 3'd1, 3'd0, 3'd5, 10'd0, 32'd0), "sndt");
        check("sndt_data_const", send_to_tile_data[160 +: 32], 32'hA5A5A5A5);
        check("sndt_addr_const", send_to_tile_addr[15 +: 3], 3'd6);
        other = send_to_tile_data;
        other[160 +: 32] = '0;
        check("sndt_other_lanes", other, '0);

        // RCVT lane 2 -> r7
        recv_from_tile_data = {$urandom, $urandom, $urandom, $urandom,
                               $urandom, $urandom, $urandom, $urandom};
        recv_from_tile_addr = 24'($urandom);
        recv_from_tile_data[64 +: 32] = 32'h12345678;
        recv_from_tile_addr[6 +: 3]   = 3'd7;
        step(ins(4'hD, 3'd0, 3'd0, 3'd0, 3'd2, 10'd0, 32'd0), "rcvt");
        step(ins(4'hE, 3'd0, 3'd7, 3'd0, 3'd0, 10'd0, 32'd0), "out_rcvt");
        check("rcvt_const", final_output, 32'h12345678);

        // LDM -> r3
        recv_from_memory_data = 32'hCAFEF00D;
        recv_from_memory_addr = 3'd3;
        step(ins(4'hF, 3'd0, 3'd0, 3'd0, 3'd0, 10'd0, 32'd0), "ldm");
        step(ins(4'hE, 3'd0, 3'd3, 3'd0, 3'd0, 10'd0, 32'd0), "out_ldm");
        check("ldm_const", final_output, 32'hCAFEF00D);

        // MUL (or NOP when multiplier is not built)
        step(ins(4'h6, 3'd3, 3'd0, 3'd0, 3'd0, 10'd0, 32'd0), "ldi");
        step(ins(4'h6, 3'd1, 3'd0, 3'd0, 3'd0, 10'd0, 32'd6), "ldi");
        step(ins(4'h6, 3'd2, 3'd0, 3'd0, 3'd0, 10'd0, 32'd7), "ldi");
        step(ins(4'hA, 3'd3, 3'd1, 3'd2, 3'd0, 10'd0, 32'd0), "mul");
        step(ins(4'hE, 3'd0, 3'd3, 3'd0, 3'd0, 10'd0, 32'd0), "out_mul");
        check("mul_const", final_output, EXP_MUL);

        // Shift amount uses only the low 5 bits; rd == rs1 reads old value
        step(ins(4'h6, 3'd1, 3'd0, 3'd0, 3'd0, 10'd0, 32'h80000001), "ldi");
        step(ins(4'h6, 3'd2, 3'd0, 3'd0, 3'd0, 10'd0, 32'hFFFFFFE1), "ldi");
        step(ins(4'h8, 3'd4, 3'd1, 3'd2, 3'd0, 10'd0, 32'd0), "shl");
        step(ins(4'hE, 3'd0, 3'd4, 3'd0, 3'd0, 10'd0, 32'd0), "out_shl");
        check("shl_const", final_output, 32'h00000002);
        step(ins(4'h9, 3'd1, 3'd1, 3'd2, 3'd0, 10'd0, 32'd0), "shr");
        step(ins(4'hE, 3'd0, 3'd1, 3'd0, 3'd0, 10'd0, 32'd0), "out_shr");
        check("shr_const", final_output, 32'h40000000);

        // Randomized program
        for (int n = 0; n < 600; n++) begin
            recv_from_memory_data = $urandom;
            recv_from_memory_addr = 3'($urandom);
            recv_from_tile_data   = {$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom};
            recv_from_tile_addr   = 24'($urandom);
            step({$urandom, $urandom}, "rand");
        end

        // Mid-cycle asynchronous reset
        rst = 1'b1;
        #1;
        model_reset();
        check_zero_outputs("async_rst");
        instruction = ins(4'hC, 3'd7, 3'd1, 3'd0, 3'd3, 10'd0, 32'd0);
        @(posedge clk);
        #1;
        check_zero_outputs("rst_hold");
        @(negedge clk);
        rst = 1'b0;
        for (int r = 0; r < 8; r++) begin
            step(ins(4'hE, 3'd0, 3'(r), 3'd0, 3'd0, 10'd0, 32'd0), "post_rst_out");
        end
        for (int n = 0; n < 100; n++) begin
            recv_from_memory_data = $urandom;
            recv_from_memory_addr = 3'($urandom);
            recv_from_tile_data   = {$urandom, $urandom, $urandom, $urandom,
                                     $urandom, $urandom, $urandom, $urandom};
            recv_from_tile_addr   = 24'($urandom);
            step({$urandom, $urandom}, "rand2");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
